// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: channel modes, blink phase,
// default prescaler divide and the channel-index width helper.
package led_pattern_pkg;

    localparam logic [1:0] LED_MODE_OFF     = 2'd0;
    localparam logic [1:0] LED_MODE_ON      = 2'd1;
    localparam logic [1:0] LED_MODE_BLINK   = 2'd2;
    localparam logic [1:0] LED_MODE_ONESHOT = 2'd3;

    typedef enum logic {
        ON_PH  = 1'b0,
        OFF_PH = 1'b1
    } led_phase_e;

    localparam int LED_DEF_TICK_DIV = 50000;

    function automatic int led_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_chan_fsm.sv
// One LED channel: mode, blink phase and phase counter, advanced on prescaler
// ticks. Produces the unregistered pattern bit; the top level registers it.
module led_chan_fsm
    import led_pattern_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [1:0]       i_mode,
    input  logic [PER_W-1:0] i_on_ticks,
    input  logic [PER_W-1:0] i_off_ticks,
    output logic             o_pattern
);

    logic [1:0]       r_mode,  w_mode;
    led_phase_e       r_phase, w_phase;
    logic [PER_W-1:0] r_cnt,   w_cnt;
    logic [PER_W-1:0] r_on,    w_on;
    logic [PER_W-1:0] r_off,   w_off;

    // r_cnt stays below the active limit, so the increment never wraps
    logic [PER_W-1:0] w_cnt_inc;
    logic [PER_W-1:0] w_limit;
    assign w_cnt_inc = r_cnt + PER_W'(1);
    assign w_limit   = (r_phase == ON_PH) ? r_on : r_off;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode  <= LED_MODE_OFF;
            r_phase <= ON_PH;
            r_cnt   <= '0;
            r_on    <= PER_W'(1);
            r_off   <= PER_W'(1);
        end else begin
            r_mode  <= w_mode;
            r_phase <= w_phase;
            r_cnt   <= w_cnt;
            r_on    <= w_on;
            r_off   <= w_off;
        end
    end

    // Priority: config load, then SYNC (BLINK only), then tick
    always_comb begin
        w_mode  = r_mode;
        w_phase = r_phase;
        w_cnt   = r_cnt;
        w_on    = r_on;
        w_off   = r_off;
        if (i_load) begin
            w_mode  = i_mode;
            w_on    = (i_on_ticks  == '0) ? PER_W'(1) : i_on_ticks;
            w_off   = (i_off_ticks == '0) ? PER_W'(1) : i_off_ticks;
            w_cnt   = '0;
            w_phase = ON_PH;
        end else if (i_sync && (r_mode == LED_MODE_BLINK)) begin
            w_cnt   = '0;
            w_phase = ON_PH;
        end else if (i_tick) begin
            case (r_mode)
                LED_MODE_BLINK: begin
                    if (w_cnt_inc == w_limit) begin
                        w_cnt   = '0;
                        w_phase = (r_phase == ON_PH) ? OFF_PH : ON_PH;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                LED_MODE_ONESHOT: begin
                    if (w_cnt_inc == r_on) begin
                        w_cnt  = '0;
                        w_mode = LED_MODE_OFF;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_pattern = 1'b0;
        case (r_mode)
            LED_MODE_ON:      o_pattern = 1'b1;
            LED_MODE_BLINK:   o_pattern = (r_phase == ON_PH);
            LED_MODE_ONESHOT: o_pattern = 1'b1;
            default:          o_pattern = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config decode and
// registered LED drive. Define LED_DIM_EN to add DIM_LEVEL PWM dimming.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = LED_DEF_TICK_DIV,
    parameter int PER_W    = 16,
    parameter int CH_W     = led_ch_w(NUM_LEDS)
) (
    input  logic                FAB_CLK,
    input  logic                FAB_RST,
    input  logic                ENABLE,
    input  logic                SYNC,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    input  logic [CH_W-1:0]     CFG_CHAN,
    input  logic [1:0]          CFG_MODE,
    input  logic [PER_W-1:0]    CFG_ON_TICKS,
    input  logic [PER_W-1:0]    CFG_OFF_TICKS,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED
`ifdef LED_DIM_EN
    ,
    input  logic [3:0]          DIM_LEVEL
`endif
);

    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0]     r_presc;
    logic                r_tick;
    logic                r_ready;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_pattern;
    logic [NUM_LEDS-1:0] w_load;
    logic                w_accept;

    assign w_accept  = CFG_VALID & r_ready;
    assign CFG_READY = r_ready;
    assign TICK      = r_tick;
    assign LED       = r_led;

    // Frozen prescaler also suppresses TICK, so re-enable loses no tick
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_tick  <= 1'b0;
            if (ENABLE) begin
                if (r_presc == PS_W'(TICK_DIV - 1)) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_presc <= r_presc + PS_W'(1);
                end
            end
        end
    end

    // Out-of-range channel indices match no instance and are dropped
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        assign w_load[gi] = w_accept && (CFG_CHAN == CH_W'(gi));

        led_chan_fsm #(
            .PER_W (PER_W)
        ) u_chan (
            .i_clk       (FAB_CLK),
            .i_rst       (FAB_RST),
            .i_tick      (r_tick),
            .i_sync      (SYNC),
            .i_load      (w_load[gi]),
            .i_mode      (CFG_MODE),
            .i_on_ticks  (CFG_ON_TICKS),
            .i_off_ticks (CFG_OFF_TICKS),
            .o_pattern   (w_pattern[gi])
        );
    end

`ifdef LED_DIM_EN
    logic [3:0] r_pwm;
    logic       w_dim_on;
    assign w_dim_on = (DIM_LEVEL == 4'hF) || (r_pwm < DIM_LEVEL);

    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) begin
            r_pwm <= '0;
            r_led <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            r_led <= w_pattern & {NUM_LEDS{w_dim_on}};
        end
    end
`else
    always_ff @(posedge FAB_CLK or posedge FAB_RST) begin
        if (FAB_RST) r_led <= '0;
        else         r_led <= w_pattern;
    end
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4, NUM_LEDS=4, PER_W=8;
// CH_W widened to 3 so out-of-range channel indices can be driven.
module tb_led_pattern_gen;

    logic       FAB_CLK = 1'b0;
    logic       FAB_RST = 1'b1;
    logic       ENABLE = 1'b1;
    logic       SYNC = 1'b0;
    logic       CFG_VALID = 1'b0;
    logic       CFG_READY;
    logic [2:0] CFG_CHAN = '0;
    logic [1:0] CFG_MODE = '0;
    logic [7:0] CFG_ON_TICKS = '0;
    logic [7:0] CFG_OFF_TICKS = '0;
    logic       TICK;
    logic [3:0] LED;
`ifdef LED_DIM_EN
    logic [3:0] DIM_LEVEL = 4'hF;
`endif

    int vectors = 0;
    int miscompares = 0;

    led_pattern_gen #(
        .NUM_LEDS (4),
        .TICK_DIV (4),
        .PER_W    (8),
        .CH_W     (3)
    ) dut (
        .FAB_CLK       (FAB_CLK),
        .FAB_RST       (FAB_RST),
        .ENABLE        (ENABLE),
        .SYNC          (SYNC),
        .CFG_VALID     (CFG_VALID),
        .CFG_READY     (CFG_READY),
        .CFG_CHAN      (CFG_CHAN),
        .CFG_MODE      (CFG_MODE),
        .CFG_ON_TICKS  (CFG_ON_TICKS),
        .CFG_OFF_TICKS (CFG_OFF_TICKS),
        .TICK          (TICK),
        .LED           (LED)
`ifdef LED_DIM_EN
        ,
        .DIM_LEVEL     (DIM_LEVEL)
`endif
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns sampled just after the edge that raised TICK
    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (TICK !== 1'b1 && n < 16);
        chk("tick_wait", 32'(TICK), 32'd1);
    endtask

    // One-cycle config strobe; returns one edge after it was presented
    task automatic cfg_pulse(input logic [2:0] ch, input logic [1:0] m,
                             input logic [7:0] on_t, input logic [7:0] off_t);
        CFG_CHAN      = ch;
        CFG_MODE      = m;
        CFG_ON_TICKS  = on_t;
        CFG_OFF_TICKS = off_t;
        CFG_VALID     = 1'b1;
        step();
        CFG_VALID     = 1'b0;
    endtask

    initial begin
        logic e;

        // reset state
        repeat (3) step();
        chk("rst_led",   32'(LED),       32'd0);
        chk("rst_tick",  32'(TICK),      32'd0);
        chk("rst_ready", 32'(CFG_READY), 32'd0);
        FAB_RST = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 1) begin
                chk("ready_up", 32'(CFG_READY), 32'd1);
                chk("idle_led", 32'(LED),       32'd0);
            end
            chk("tick_cadence", 32'(TICK), 32'((n % 4) == 0));
        end

        // ch1 BLINK on=2 off=3, config lands on a tick cycle
        wait_tick();
        cfg_pulse(3'd1, 2'd2, 8'd2, 8'd3);
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) step();
            e = (k >= 2) && (((k - 2) % 20) < 8);
            chk("blink_ch1", 32'(LED), 32'({2'b00, e, 1'b0}));
        end
        cfg_pulse(3'd1, 2'd0, 8'd0, 8'd0);

        // ch2 ONESHOT on=3
        wait_tick();
        cfg_pulse(3'd2, 2'd3, 8'd3, 8'd0);
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) step();
            e = (k >= 2) && (k < 14);
            chk("oneshot_ch2", 32'(LED), 32'({1'b0, e, 2'b00}));
        end

        // ch0 BLINK with zero periods, SYNC in the OFF phase
        wait_tick();
        cfg_pulse(3'd0, 2'd2, 8'd0, 8'd0);
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) step();
            if (k < 2)       e = 1'b0;
            else if (k <= 8) e = (((k - 2) / 4) % 2) == 0;
            else if (k == 9) e = 1'b1;
            else             e = (((k - 10) / 4) % 2) == 1;
            chk("blink0_sync", 32'(LED), 32'({3'b000, e}));
            if (k == 7) SYNC = 1'b1;
            if (k == 8) SYNC = 1'b0;
        end
        cfg_pulse(3'd0, 2'd0, 8'd0, 8'd0);

        // ch3 BLINK on=3 off=2, ENABLE low 50 cycles mid ON phase
        wait_tick();
        cfg_pulse(3'd3, 2'd2, 8'd3, 8'd2);
        for (int k = 1; k <= 75; k++) begin
            if (k > 1) step();
            e = ((k >= 2) && (k < 64)) || (k >= 72);
            chk("freeze_led", 32'(LED), 32'({e, 3'b000}));
            chk("freeze_tick", 32'(TICK),
                32'(((k < 7) && (k % 4 == 0)) || ((k >= 58) && ((k - 58) % 4 == 0))));
            if (k == 6)  ENABLE = 1'b0;
            if (k == 56) ENABLE = 1'b1;
        end

        // out-of-range channels are accepted and dropped
        CFG_CHAN  = 3'd7;
        CFG_MODE  = 2'd0;
        CFG_VALID = 1'b1;
        step();
        chk("bad_chan", 32'(LED), 32'h8);
        CFG_CHAN = 3'd5;
        CFG_MODE = 2'd1;
        step();
        CFG_VALID = 1'b0;
        chk("bad_chan", 32'(LED), 32'h8);
        for (int k = 78; k <= 83; k++) begin
            step();
            chk("bad_chan", 32'(LED), 32'h8);
        end

        // asynchronous reset mid BLINK
        #2 FAB_RST = 1'b1;
        #1;
        chk("async_rst_led",   32'(LED),       32'd0);
        chk("async_rst_tick",  32'(TICK),      32'd0);
        chk("async_rst_ready", 32'(CFG_READY), 32'd0);
        step();
        step();
        FAB_RST = 1'b0;
        step();
        chk("post_rst_ready", 32'(CFG_READY), 32'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("post_rst_off", 32'(LED), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator; successor to the fixed 4-LED fabric blinker.
- A shared prescaler produces a periodic tick. Each channel runs an independently configured mode: OFF, ON, BLINK (programmable on/off tick counts) or ONESHOT.
- Configured at runtime over a valid/ready strobe interface from the fabric/MSS glue logic.
- Drives board LEDs directly.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..16).
- TICK_DIV, 50000, FAB_CLK cycles per tick (1 ms at 50 MHz); must be >= 2.
- PER_W, 16, width of on/off tick-count fields.
- CH_W, $clog2(NUM_LEDS) min 1, width of channel index.

Ports:
- FAB_CLK  input  1  fabric clock; all logic on its rising edge.
- FAB_RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  1 = prescaler runs; 0 = prescaler frozen, LED patterns hold.
- SYNC  input  1  single-cycle strobe; restarts every BLINK channel at start of ON phase.
- CFG_VALID  input  1  configuration request.
- CFG_READY  output  1  block can accept configuration.
- CFG_CHAN  input  CH_W  target channel.
- CFG_MODE  input  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- CFG_ON_TICKS  input  PER_W  ticks high per period (BLINK/ONESHOT).
- CFG_OFF_TICKS  input  PER_W  ticks low per period (BLINK).
- TICK  output  1  one-cycle pulse each prescaler wrap (debug/chaining).
- LED  output  NUM_LEDS  registered LED drive, bit i = channel i.

Behaviour:
- Reset (async assert, sync release by FAB_CLK domain):
  - LED=0, TICK=0, CFG_READY=0.
  - Prescaler=0; every channel mode=OFF, on/off=1, phase counter=0, phase=ON_PH.
- CFG_READY is 1 from the first clock after reset deassertion onward; 0 only during reset.
- Prescaler counts 0..TICK_DIV-1 while ENABLE=1; holds its value while ENABLE=0.
  - TICK=1 for exactly the cycle after the counter reaches TICK_DIV-1 (registered), then the counter wraps to 0.
- Config accept occurs when CFG_VALID & CFG_READY in cycle N:
  - Channel CFG_CHAN loads mode, on_ticks and off_ticks; a value of 0 is stored as 1.
  - Phase counter clears; phase=ON_PH.
  - LED reflects the new mode at the edge ending cycle N+1 (1-cycle latency).
  - CFG_CHAN >= NUM_LEDS: accepted, discarded, no state change.
- Per-channel state machine, evaluated only on TICK cycles (except OFF/ON):
  - OFF: LED=0.
  - ON: LED=1.
  - BLINK ON_PH: LED=1; on tick, cnt+1; when cnt+1==on_ticks -> cnt=0, OFF_PH.
  - BLINK OFF_PH: LED=0; on tick, cnt+1; when cnt+1==off_ticks -> cnt=0, ON_PH.
  - Resulting period: (on+off)*TICK_DIV cycles.
  - ONESHOT: LED=1 for on_ticks ticks, then mode becomes OFF and LED=0. Re-config restarts it.
- Phase counters are PER_W bits; equality compare prevents wrap. A max value of 2^PER_W-1 is legal.
- Simultaneous events:
  - Config and tick on the same channel: config wins; that tick is ignored for that channel.
  - SYNC and tick: SYNC wins.
  - SYNC and config: config loads, phase resets (same result).
  - SYNC does not affect OFF/ON/ONESHOT channels.
- ENABLE=0 mid-pattern freezes phase and LED levels; re-enable resumes with no lost or extra tick.
- Reset mid-operation discards all configuration; LEDs go 0 immediately (async).

Optional Feature:
- LED_DIM_EN defined:
  - Adds input DIM_LEVEL [3:0] and a free-running 4-bit pwm counter.
  - LED[i] = pattern[i] & (pwm_cnt < DIM_LEVEL); DIM_LEVEL=4'hF forces full on.
  - DIM_LEVEL=0 blanks all LEDs; output remains registered.
- Undefined: no DIM_LEVEL port, no pwm counter; LED = pattern.

Decomposition:
- Package led_pattern_pkg: mode encoding constants (LED_MODE_OFF/ON/BLINK/ONESHOT), phase enum (ON_PH, OFF_PH), default TICK_DIV.
- Sub-module led_chan_fsm: one channel's mode/phase/counter logic, instantiated NUM_LEDS times via generate.
- Prescaler and config decode stay in the top level.

Test Plan (TICK_DIV=4, NUM_LEDS=4, PER_W=8):
- Reset release, no config -> LED=4'b0000, CFG_READY=1 on first post-reset cycle, TICK every 4th cycle.
- Config ch1 BLINK on=2 off=3 -> LED[1] high 8 cycles, low 12 cycles, repeating; other bits stay 0.
- Config ch2 ONESHOT on=3 -> LED[2] high 12 cycles then 0 permanently; ch2 reads back as OFF behaviour.
- Config ch0 BLINK on=0 off=0, then SYNC mid OFF_PH -> zero treated as 1 (toggle every tick); LED[0]=1 the cycle after SYNC.
- ENABLE low for 50 cycles mid ON_PH on a BLINK channel -> LED frozen at 1; remaining ON ticks complete after re-enable; CFG_CHAN=7 with CFG_VALID -> no LED change.
- Assert FAB_RST mid BLINK -> LED=0 asynchronously; after release all channels OFF. With LED_DIM_EN, DIM_LEVEL=4 on ON channel -> LED high 4 of every 16 cycles.
